ram_load_arbiter: RTL and testbench
===================================

Name: ram_load_arbiter

Overview:
- Shares the CPU's 8-bit bus, MAR and 16-byte RAM between the instruction sequencer and an external program loader/debug port.
- On a loader request it waits for an instruction boundary, halts the CPU, then runs burst writes into RAM through MAR and bus using a valid/ready handshake.
- Releases the CPU when the burst completes.
- Sits beside the controller; its bus/MAR/RAM strobes are OR-ed into the existing control lines while cpu_halt is high.

Parameters:
- ADDR_W, 4, RAM address width (RAM depth = 2**ADDR_W).
- DATA_W, 8, bus width.
- BND_TIMEOUT, 31, max cycles to wait for an instruction boundary before flagging ld_err; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- cpu_boundary  input  1  high in the cycle the controller is at step 0 before a fetch.
- cpu_halt  output  1  freezes controller/PC/decoder advance while high.
- ld_req  input  1  loader requests RAM; level, held until ld_done.
- ld_start_addr  input  ADDR_W  first RAM address; sampled at grant.
- ld_len  input  ADDR_W+1  byte count, 1..16; sampled at grant.
- ld_gnt  output  1  high from grant until ld_done.
- ld_data  input  DATA_W  write byte.
- ld_valid  input  1  ld_data valid.
- ld_ready  output  1  byte accepted when ld_valid && ld_ready.
- ld_done  output  1  one-cycle pulse at burst end.
- ld_err  output  1  sticky error flag; cleared on next grant.
- arb_bus  output  DATA_W  value driven onto the bus.
- arb_bus_en  output  1  arb_bus drives the bus (tristate enable).
- arb_mar_load  output  1  MAR load strobe.
- arb_ram_write  output  1  RAM write strobe.
- arb_ram_read  output  1  RAM read strobe (used only with the optional feature).

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0; internal address and count cleared.
- IDLE: if ld_req is high, go to WAIT_BND and assert cpu_halt request.
- WAIT_BND:
  - cpu_boundary high: assert cpu_halt from the next edge; latch start address into addr_q and ld_len into cnt_q; clear ld_err; assert ld_gnt; go to ACCEPT.
  - ld_len == 0 at this point: treat as a 1-byte burst (no error).
  - No boundary within BND_TIMEOUT cycles: set ld_err, pulse ld_done, go to IDLE. The CPU is never halted in this case.
  - ld_req dropping here returns to IDLE silently.
- ACCEPT:
  - ld_ready = 1.
  - On handshake: capture ld_data into data_q, go to ADDR.
  - No handshake: stay (stalls are unbounded).
- ADDR: arb_bus = {0, addr_q}; arb_bus_en = 1; arb_mar_load = 1; go to DATA.
- DATA: arb_bus = data_q; arb_bus_en = 1; arb_ram_write = 1; addr_q += 1 (wraps 15 -> 0); cnt_q -= 1.
  - cnt_q reaches 0: go to DONE.
  - Otherwise: go to ACCEPT.
- DONE: ld_done = 1 for one cycle; cpu_halt and ld_gnt deassert at the next edge; go to IDLE.
- Back-to-back: ld_req still high in IDLE re-arbitrates, so the CPU must reach another boundary first.
- Throughput: 3 cycles per byte minimum (ACCEPT, ADDR, DATA).
- ld_req dropping after grant is ignored; the burst always completes.
- Mutual exclusion: arb_bus_en is never high unless cpu_halt has been high for at least 1 cycle.
- Asynchronous reset mid-burst: aborts immediately; cpu_halt drops; a partial RAM write is allowed.

Optional Feature:
- Macro ARB_READBACK_EN.
- Defined: after DATA, a VERIFY state asserts arb_ram_read for 1 cycle, samples the bus, and compares against data_q. On mismatch, set ld_err (sticky until the next grant). 4 cycles/byte.
- Undefined: no VERIFY state; arb_ram_read is tied 0; ld_err is set only by boundary timeout.

Test Plan:
- Reset with rst=0 during a burst -> all outputs 0 within the same cycle; cpu_halt=0.
- ld_req with start=0x3, len=3, data 0xA1/0xB2/0xC3, cpu_boundary pulse 4 cycles later -> halt only after the boundary; MAR loads 0x03/0x04/0x05; RAM writes A1/B2/C3; ld_done 1 cycle; halt released.
- start=0xF, len=2 -> writes to 0xF then 0x0 (wrap).
- ld_valid withheld 10 cycles mid-burst -> stays in ACCEPT; no strobes; completes after valid.
- cpu_boundary never asserted, BND_TIMEOUT=31 -> ld_err=1 and ld_done pulse at cycle 32; cpu_halt never high.
- With ARB_READBACK_EN, RAM model corrupts address 0x4 -> ld_err=1 after that byte; burst completes.

Source files
------------

// File: rtl/ram_load_arbiter.sv
// Loader/debug-port arbiter: halts the CPU at an instruction boundary and burst-writes RAM via MAR and bus.
// Optional RAM read-back verify of every written byte is enabled by defining ARB_READBACK_EN.
module ram_load_arbiter #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int BND_TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_boundary,
  output logic              cpu_halt,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_start_addr,
  input  logic [ADDR_W:0]   ld_len,
  output logic              ld_gnt,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err,
  output logic [DATA_W-1:0] arb_bus,
  output logic              arb_bus_en,
  output logic              arb_mar_load,
  output logic              arb_ram_write,
  output logic              arb_ram_read
`ifdef ARB_READBACK_EN
  ,
  input  logic [DATA_W-1:0] bus_rd_i
`endif
);

  // state    | meaning
  // IDLE     | CPU runs freely, no request pending
  // WAIT_BND | request seen, waiting for an instruction boundary (timed)
  // ACCEPT   | CPU halted, waiting for the next loader byte
  // ADDR     | address on bus, MAR load
  // DATA     | byte on bus, RAM write
  // VERIFY   | RAM read-back compare (ARB_READBACK_EN only)
  // DONE     | ld_done pulse, halt released at the next edge
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BND, S_ACCEPT, S_ADDR, S_DATA, S_VERIFY, S_DONE
  } state_t;

  localparam int TMR_W = (BND_TIMEOUT > 1) ? $clog2(BND_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_INIT = (BND_TIMEOUT > 0) ? TMR_W'(BND_TIMEOUT - 1) : '0;
  localparam logic [ADDR_W:0]  LEN_ONE  = (ADDR_W+1)'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                err_q, err_d;
  logic                done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    tmr_d         = tmr_q;
    err_d         = err_q;
    done_d        = 1'b0;
    cpu_halt      = 1'b0;
    ld_gnt        = 1'b0;
    ld_ready      = 1'b0;
    arb_bus       = '0;
    arb_bus_en    = 1'b0;
    arb_mar_load  = 1'b0;
    arb_ram_write = 1'b0;
    arb_ram_read  = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmr_d = TMR_INIT;
        if (ld_req) state_d = S_WAIT_BND;
      end
      S_WAIT_BND: begin
        if (!ld_req) begin
          state_d = S_IDLE;
        end else if (cpu_boundary) begin
          addr_d  = ld_start_addr;
          cnt_d   = (ld_len == '0) ? LEN_ONE : ld_len;
          err_d   = 1'b0;
          state_d = S_ACCEPT;
        end else if (BND_TIMEOUT != 0 && tmr_q == '0) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_ACCEPT: begin
        cpu_halt = 1'b1;
        ld_gnt   = 1'b1;
        ld_ready = 1'b1;
        if (ld_valid) begin
          data_d  = ld_data;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        cpu_halt     = 1'b1;
        ld_gnt       = 1'b1;
        arb_bus      = {{(DATA_W-ADDR_W){1'b0}}, addr_q};
        arb_bus_en   = 1'b1;
        arb_mar_load = 1'b1;
        state_d      = S_DATA;
      end
      S_DATA: begin
        cpu_halt      = 1'b1;
        ld_gnt        = 1'b1;
        arb_bus       = data_q;
        arb_bus_en    = 1'b1;
        arb_ram_write = 1'b1;
        addr_d        = addr_q + 1'b1;
        cnt_d         = cnt_q - 1'b1;
`ifdef ARB_READBACK_EN
        state_d       = S_VERIFY;
`else
        if (cnt_q == LEN_ONE) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_ACCEPT;
        end
`endif
      end
`ifdef ARB_READBACK_EN
      S_VERIFY: begin
        cpu_halt     = 1'b1;
        ld_gnt       = 1'b1;
        arb_ram_read = 1'b1;
        if (bus_rd_i != data_q) err_d = 1'b1;
        // cnt_q was already decremented in DATA
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_ACCEPT;
        end
      end
`endif
      S_DONE: begin
        cpu_halt = 1'b1;
        ld_gnt   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ld_done = done_q;
  assign ld_err  = err_q;

endmodule

// File: tb/tb_ram_load_arbiter.sv
// Directed bench for ram_load_arbiter with a MAR/RAM model and a bus-ownership monitor.
module tb_ram_load_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpu_boundary = 1'b0;
  logic       cpu_halt;
  logic       ld_req = 1'b0;
  logic [3:0] ld_start_addr = '0;
  logic [4:0] ld_len = '0;
  logic       ld_gnt;
  logic [7:0] ld_data = '0;
  logic       ld_valid = 1'b0;
  logic       ld_ready, ld_done, ld_err;
  logic [7:0] arb_bus;
  logic       arb_bus_en, arb_mar_load, arb_ram_write, arb_ram_read;

  int n_assert = 0;
  int n_fail   = 0;
  int mx_viol  = 0;

  logic [3:0] mar = '0;
  logic [7:0] ram [16];
  logic [3:0] mar_log [$];
  logic       halt_prev = 1'b0;

`ifdef ARB_READBACK_EN
  logic [7:0] bus_rd;
  assign bus_rd = (mar == 4'h4) ? (ram[mar] ^ 8'hFF) : ram[mar];
`endif

  ram_load_arbiter #(.ADDR_W(4), .DATA_W(8), .BND_TIMEOUT(31)) dut (
    .clk(clk), .rst(rst), .cpu_boundary(cpu_boundary), .cpu_halt(cpu_halt),
    .ld_req(ld_req), .ld_start_addr(ld_start_addr), .ld_len(ld_len), .ld_gnt(ld_gnt),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_done(ld_done),
    .ld_err(ld_err), .arb_bus(arb_bus), .arb_bus_en(arb_bus_en),
    .arb_mar_load(arb_mar_load), .arb_ram_write(arb_ram_write), .arb_ram_read(arb_ram_read)
`ifdef ARB_READBACK_EN
    , .bus_rd_i(bus_rd)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    halt_prev <= cpu_halt;
    if (arb_mar_load) begin
      mar <= arb_bus[3:0];
      mar_log.push_back(arb_bus[3:0]);
    end
    if (arb_ram_write) ram[mar] <= arb_bus;
  end

  always @(negedge clk) begin
    if (rst && arb_bus_en && !halt_prev) mx_viol++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Enters with the DUT in ACCEPT; leaves it in ACCEPT, or in IDLE after the release when last=1.
  task automatic do_byte(input logic [3:0] a, input logic [7:0] d, input bit last);
    chk("accept_ready", {31'd0, ld_ready}, 32'd1);
    ld_valid = 1'b1;
    ld_data  = d;
    tick;
    ld_valid = 1'b0;
    ld_data  = '0;
    chk("addr_phase", {21'd0, arb_bus_en, arb_mar_load, arb_ram_write, arb_bus},
        {21'd0, 3'b110, 4'h0, a});
    tick;
    chk("data_phase", {21'd0, arb_bus_en, arb_mar_load, arb_ram_write, arb_bus},
        {21'd0, 3'b101, d});
    tick;
`ifdef ARB_READBACK_EN
    chk("verify_read", {31'd0, arb_ram_read}, 32'd1);
    tick;
`endif
    if (last) begin
      chk("done_pulse", {28'd0, ld_done, cpu_halt, ld_gnt, ld_ready}, {28'd0, 4'b1110});
      ld_req = 1'b0;
      tick;
      chk("release", {29'd0, ld_done, cpu_halt, ld_gnt}, 32'd0);
    end else begin
      chk("next_accept", {30'd0, ld_done, ld_ready}, {30'd0, 2'b01});
    end
  endtask

  task automatic grant(input logic [3:0] s, input logic [4:0] len);
    ld_start_addr = s;
    ld_len        = len;
    ld_req        = 1'b1;
    tick;
    chk("wait_no_halt", {31'd0, cpu_halt}, 32'd0);
    cpu_boundary = 1'b1;
    tick;
    cpu_boundary = 1'b0;
    chk("granted", {29'd0, cpu_halt, ld_gnt, ld_ready}, {29'd0, 3'b111});
  endtask

  initial begin
    #2;
    chk("reset_outputs",
        {15'd0, cpu_halt, ld_gnt, ld_ready, ld_done, ld_err, arb_bus, arb_bus_en,
         arb_mar_load, arb_ram_write, arb_ram_read}, 32'd0);
    tick;
    rst = 1'b1;
    tick;

    // burst of 3 at 0x3, boundary arrives 4 cycles after the request
    ld_start_addr = 4'h3;
    ld_len        = 5'd3;
    ld_req        = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) begin
      chk("halt_before_bnd", {30'd0, cpu_halt, arb_bus_en}, 32'd0);
      tick;
    end
    cpu_boundary = 1'b1;
    chk("halt_at_bnd", {31'd0, cpu_halt}, 32'd0);
    tick;
    cpu_boundary = 1'b0;
    chk("granted_a", {29'd0, cpu_halt, ld_gnt, ld_ready}, {29'd0, 3'b111});
    do_byte(4'h3, 8'hA1, 1'b0);
    do_byte(4'h4, 8'hB2, 1'b0);
    do_byte(4'h5, 8'hC3, 1'b1);
    chk("ram3", {24'd0, ram[3]}, 32'hA1);
    chk("ram4", {24'd0, ram[4]}, 32'hB2);
    chk("ram5", {24'd0, ram[5]}, 32'hC3);
    chk("mar_count", mar_log.size(), 32'd3);
    chk("mar_seq", {20'd0, mar_log[0], mar_log[1], mar_log[2]}, {20'd0, 12'h345});
`ifdef ARB_READBACK_EN
    chk("readback_err", {31'd0, ld_err}, 32'd1);
`else
    chk("no_err_a", {31'd0, ld_err}, 32'd0);
`endif

    // address wrap 0xF -> 0x0
    grant(4'hF, 5'd2);
    do_byte(4'hF, 8'h5A, 1'b0);
    do_byte(4'h0, 8'h6B, 1'b1);
    chk("ramF", {24'd0, ram[15]}, 32'h5A);
    chk("ram0", {24'd0, ram[0]}, 32'h6B);
    chk("no_err_b", {31'd0, ld_err}, 32'd0);

    // loader stall of 10 cycles between bytes
    grant(4'h8, 5'd2);
    do_byte(4'h8, 8'h11, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("stall", {27'd0, ld_ready, cpu_halt, arb_bus_en, arb_mar_load, arb_ram_write},
          {27'd0, 5'b11000});
    end
    do_byte(4'h9, 8'h22, 1'b1);
    chk("ram8", {24'd0, ram[8]}, 32'h11);
    chk("ram9", {24'd0, ram[9]}, 32'h22);

    // zero length behaves as a single byte
    grant(4'h2, 5'd0);
    do_byte(4'h2, 8'h77, 1'b1);
    chk("ram2", {24'd0, ram[2]}, 32'h77);

    // boundary timeout: 31 waiting cycles, done/err on the 32nd edge
    ld_req = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      tick;
      chk("tmo_wait", {29'd0, cpu_halt, ld_done, ld_err}, 32'd0);
    end
    tick;
    chk("tmo_flag", {29'd0, cpu_halt, ld_done, ld_err}, {29'd0, 3'b011});
    ld_req = 1'b0;
    tick;
    chk("tmo_sticky", {29'd0, cpu_halt, ld_done, ld_err}, {29'd0, 3'b001});
    tick;
    grant(4'hA, 5'd1);
    chk("err_cleared", {31'd0, ld_err}, 32'd0);
    do_byte(4'hA, 8'h3C, 1'b1);
    chk("ramA", {24'd0, ram[10]}, 32'h3C);

    // request withdrawn while waiting for the boundary
    ld_req = 1'b1;
    tick;
    ld_req = 1'b0;
    tick;
    tick;
    chk("withdraw", {28'd0, cpu_halt, ld_gnt, ld_done, ld_err}, 32'd0);

    // asynchronous reset mid-burst
    grant(4'h1, 5'd2);
    ld_valid = 1'b1;
    ld_data  = 8'h99;
    tick;
    ld_valid = 1'b0;
    chk("pre_reset_addr", {30'd0, arb_bus_en, cpu_halt}, {30'd0, 2'b11});
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset",
        {15'd0, cpu_halt, ld_gnt, ld_ready, ld_done, ld_err, arb_bus, arb_bus_en,
         arb_mar_load, arb_ram_write, arb_ram_read}, 32'd0);
    ld_req = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    chk("post_reset_idle", {30'd0, cpu_halt, ld_gnt}, 32'd0);

    chk("bus_mutex", mx_viol, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
